// File: rtl/latency_return_buffer_pkg.sv
// -----------------------------------------------------------------------------
// latency_return_buffer_pkg
//
// Purpose : Small helper package for the latency return buffer. It holds the
//           operation encodings that the credit counter and the return FIFO
//           decode every cycle.
// Contents: fifo_op_e   - {pop, push} pair seen by the return FIFO
//           credit_op_e - {give, take} pair seen by the credit counter
// -----------------------------------------------------------------------------
package latency_return_buffer_pkg;

    // Bit 0 = push, bit 1 = pop, so a cast from {pop, push} is direct.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Bit 0 = credit taken by an accepted input, bit 1 = credit given back
    // by a drained output. Taking and giving together leaves the count alone.
    typedef enum logic [1:0] {
        CREDIT_HOLD = 2'b00,
        CREDIT_TAKE = 2'b01,
        CREDIT_GIVE = 2'b10,
        CREDIT_SWAP = 2'b11
    } credit_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

    function automatic credit_op_e credit_op(input logic take, input logic give);
        return credit_op_e'({give, take});
    endfunction

endpackage

// File: rtl/latency_return_fifo.sv
// -----------------------------------------------------------------------------
// latency_return_fifo
//
// Purpose : Circular return buffer that catches every word leaving the fixed
//           latency pipeline. Head is presented directly from storage (no
//           fall-through: a word pushed into an empty FIFO shows up on valid_o
//           the following cycle).
// Ports   : clk_i        - clock, rising edge
//           rst_i        - synchronous active-high reset; pushes are ignored
//                          while it is high
//           push_i       - write strobe (pipeline output valid)
//           push_data_i  - write payload
//           pop_i        - head consumed this cycle
//           valid_o      - FIFO not empty
//           data_o       - head payload
//           count_o      - number of stored entries, 0..Depth
// -----------------------------------------------------------------------------
module latency_return_fifo
    import latency_return_buffer_pkg::*;
#(
    parameter type           dtype = logic,
    parameter int unsigned   Depth = 4,
    localparam int unsigned  CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  dtype            push_data_i,
    input  logic            pop_i,
    output logic            valid_o,
    output dtype            data_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    dtype            mem_reg [Depth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;

    logic     full;
    logic     pop_ok;
    logic     push_ok;
    fifo_op_e op;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_reg == FullCnt);
    assign pop_ok  = pop_i && (count_reg != '0);
    // A pop in the same cycle frees the slot being written, so a push at
    // full is still legal then. Without the pop the word is discarded.
    assign push_ok = push_i && (!full || pop_ok);
    assign op      = fifo_op(push_ok, pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    count_reg  <= count_reg + 1'b1;
                end
                FIFO_POP: begin
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    count_reg  <= count_reg - 1'b1;
                end
                FIFO_BOTH: begin
                    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    assign valid_o = (count_reg != '0);
    assign data_o  = mem_reg[rd_ptr_reg];
    assign count_o = count_reg;

    // A push into a full FIFO with no pop means the credit accounting upstream
    // was bypassed.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full && !pop_ok));

    a_count_bounded : assert property (@(posedge clk_i) disable iff (rst_i)
        count_reg <= FullCnt);

endmodule

// File: rtl/latency_return_buffer.sv
// -----------------------------------------------------------------------------
// latency_return_buffer
//
// Purpose : Puts a fixed-latency, non-stallable pipeline behind a valid/ready
//           interface. Upstream transfers are admitted only while a credit
//           (a guaranteed slot in the return FIFO) is available, forwarded
//           straight into the pipeline, and whatever the pipeline emits is
//           captured in the return FIFO for the downstream consumer.
// Ports   : clk_i        - clock, rising edge
//           rst_i        - synchronous active-high reset (reset the pipeline
//                          in the same cycle)
//           in_valid_i   - upstream valid
//           in_ready_o   - upstream may transfer (credit available)
//           in_data_i    - upstream payload
//           pipe_valid_o - issue strobe into the pipeline
//           pipe_data_o  - payload into the pipeline
//           pipe_valid_i - pipeline output valid
//           pipe_data_i  - pipeline output payload
//           out_valid_o  - return FIFO head valid
//           out_ready_i  - downstream accepts head
//           out_data_o   - return FIFO head payload
// Params  : dtype (payload type), Latency (pipeline depth, 0 = wire),
//           Depth (return FIFO entries; Depth >= Latency+2 sustains one
//           transfer per cycle)
// -----------------------------------------------------------------------------
module latency_return_buffer
    import latency_return_buffer_pkg::*;
#(
    parameter type         dtype   = logic,
    parameter int unsigned Latency = 1,
    parameter int unsigned Depth   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  dtype in_data_i,
    output logic pipe_valid_o,
    output dtype pipe_data_o,
    input  logic pipe_valid_i,
    input  dtype pipe_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output dtype out_data_o
);

    localparam int unsigned     CntW       = $clog2(Depth + 1);
    localparam logic [CntW-1:0] FullCredit = CntW'(Depth);

    logic [CntW-1:0] credit_reg;
    logic [CntW-1:0] credit_next;
    logic [CntW-1:0] fifo_count;
    logic            fire_in;
    logic            fire_out;

    // ready depends only on the credit register, never on out_ready_i.
    assign in_ready_o   = (credit_reg != '0);
    // Nothing is issued into the pipeline while reset is applied, so the
    // pipeline and the credit count restart from the same empty state.
    assign fire_in      = in_valid_i & in_ready_o & ~rst_i;
    assign pipe_valid_o = fire_in;
    assign pipe_data_o  = in_data_i;

    assign fire_out     = out_valid_o & out_ready_i;

    always_comb begin
        credit_next = credit_reg;
        case (credit_op(fire_in, fire_out))
            CREDIT_TAKE: credit_next = credit_reg - 1'b1;
            CREDIT_GIVE: credit_next = credit_reg + 1'b1;
            default:     credit_next = credit_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_reg <= FullCredit;
        end else begin
            credit_reg <= credit_next;
        end
    end

    latency_return_fifo #(
        .dtype (dtype),
        .Depth (Depth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (pipe_valid_i),
        .push_data_i (pipe_data_i),
        .pop_i       (fire_out),
        .valid_o     (out_valid_o),
        .data_o      (out_data_o),
        .count_o     (fifo_count)
    );

    // issue_tap[k] is fire_in delayed by k cycles. The last tap is when the
    // pipeline must present that word on pipe_valid_i; it exists only to check
    // that the attached pipeline really has the configured latency and is
    // reset together with this block.
    logic [Latency:0] issue_tap;
    assign issue_tap[0] = fire_in;

    for (genvar gi = 0; gi < Latency; gi++) begin : g_issue_track
        logic stage_reg;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_reg <= 1'b0;
            end else begin
                stage_reg <= issue_tap[gi];
            end
        end
        assign issue_tap[gi+1] = stage_reg;
    end

    a_credit_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(fire_in && !fire_out && (credit_reg == '0)));

    a_credit_bounded : assert property (@(posedge clk_i) disable iff (rst_i)
        credit_reg <= FullCredit);

    // Stored entries plus outstanding credits can never exceed the FIFO size;
    // the difference is the number of words still inside the pipeline.
    a_credit_vs_count : assert property (@(posedge clk_i) disable iff (rst_i)
        (int'(fifo_count) + int'(credit_reg)) <= int'(Depth));

    a_pipe_latency : assert property (@(posedge clk_i) disable iff (rst_i)
        pipe_valid_i == issue_tap[Latency]);

endmodule

// File: tb/tb_latency_return_buffer.sv
// -----------------------------------------------------------------------------
// tb_latency_return_buffer
//
// Three buffer instances, each wrapping a behavioural delay-chain pipeline:
//   u_a : Latency=1, Depth=4  (reset, single transfer, backpressure, mid reset)
//   u_b : Latency=2, Depth=4  (100-word stream at full rate)
//   u_c : Latency=3, Depth=2  (under-provisioned, 2 accepts per 5 cycles)
// Stimulus pushes the words it expects to be accepted into per-instance
// queues; monitors on the falling edge pop and compare whenever a word leaves.
// -----------------------------------------------------------------------------
module tb_latency_return_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_in_valid, a_in_ready, a_pv_o, a_pv_i, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_pd_o, a_pd_i, a_out_data;
    logic       b_in_valid, b_in_ready, b_pv_o, b_pv_i, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_pd_o, b_pd_i, b_out_data;
    logic       c_in_valid, c_in_ready, c_pv_o, c_pv_i, c_out_valid, c_out_ready;
    logic [7:0] c_in_data, c_pd_o, c_pd_i, c_out_data;

    logic       inject_v;
    logic [7:0] inject_d;

    int n_checks;
    int n_pass;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_c[$];

    latency_return_buffer #(.dtype(logic [7:0]), .Latency(1), .Depth(4)) u_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .pipe_valid_o(a_pv_o), .pipe_data_o(a_pd_o),
        .pipe_valid_i(a_pv_i), .pipe_data_i(a_pd_i),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data)
    );

    latency_return_buffer #(.dtype(logic [7:0]), .Latency(2), .Depth(4)) u_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .pipe_valid_o(b_pv_o), .pipe_data_o(b_pd_o),
        .pipe_valid_i(b_pv_i), .pipe_data_i(b_pd_i),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data)
    );

    latency_return_buffer #(.dtype(logic [7:0]), .Latency(3), .Depth(2)) u_c (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
        .pipe_valid_o(c_pv_o), .pipe_data_o(c_pd_o),
        .pipe_valid_i(c_pv_i), .pipe_data_i(c_pd_i),
        .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data)
    );

    // Behavioural pipelines, reset together with the buffers.
    logic       a_stage_v;
    logic [7:0] a_stage_d;
    always @(posedge clk) begin
        if (rst) a_stage_v <= 1'b0;
        else     a_stage_v <= a_pv_o;
        a_stage_d <= a_pd_o;
    end
    // inject_v forces pipeline-output pulses while reset is held.
    assign a_pv_i = a_stage_v | inject_v;
    assign a_pd_i = inject_v ? inject_d : a_stage_d;

    logic [1:0] b_stage_v;
    logic [7:0] b_stage_d [2];
    always @(posedge clk) begin
        if (rst) b_stage_v <= '0;
        else     b_stage_v <= {b_stage_v[0], b_pv_o};
        b_stage_d[0] <= b_pd_o;
        b_stage_d[1] <= b_stage_d[0];
    end
    assign b_pv_i = b_stage_v[1];
    assign b_pd_i = b_stage_d[1];

    logic [2:0] c_stage_v;
    logic [7:0] c_stage_d [3];
    always @(posedge clk) begin
        if (rst) c_stage_v <= '0;
        else     c_stage_v <= {c_stage_v[1:0], c_pv_o};
        c_stage_d[0] <= c_pd_o;
        c_stage_d[1] <= c_stage_d[0];
        c_stage_d[2] <= c_stage_d[1];
    end
    assign c_pv_i = c_stage_v[2];
    assign c_pd_i = c_stage_d[2];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Output monitors: one line per delivered word.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL a_out_unexpected: got 0x%02h, expected no output", a_out_data);
            end else begin
                $display("a out 0x%02h", a_out_data);
                check("a_out_data", 32'(a_out_data), 32'(exp_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_out_unexpected: got 0x%02h, expected no output", b_out_data);
            end else begin
                $display("b out 0x%02h", b_out_data);
                check("b_out_data", 32'(b_out_data), 32'(exp_b.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid && c_out_ready) begin
            if (exp_c.size() == 0) begin
                n_checks++;
                $display("FAIL c_out_unexpected: got 0x%02h, expected no output", c_out_data);
            end else begin
                $display("c out 0x%02h", c_out_data);
                check("c_out_data", 32'(c_out_data), 32'(exp_c.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for one cycle; exp_acc is the hand-derived acceptance.
    task automatic offer(input int which, input logic [7:0] d, input bit exp_acc,
                         input string tag);
        logic rdy;
        case (which)
            0:       begin a_in_valid = 1'b1; a_in_data = d; end
            1:       begin b_in_valid = 1'b1; b_in_data = d; end
            default: begin c_in_valid = 1'b1; c_in_data = d; end
        endcase
        @(negedge clk);
        case (which)
            0:       rdy = a_in_ready;
            1:       rdy = b_in_ready;
            default: rdy = c_in_ready;
        endcase
        check(tag, 32'(rdy), 32'(exp_acc));
        if (exp_acc) begin
            case (which)
                0:       exp_a.push_back(d);
                1:       exp_b.push_back(d);
                default: exp_c.push_back(d);
            endcase
        end
        step();
        case (which)
            0:       a_in_valid = 1'b0;
            1:       b_in_valid = 1'b0;
            default: c_in_valid = 1'b0;
        endcase
    endtask

    // One isolated transfer through u_a with ready held high, cycle by cycle.
    task automatic single_a(input logic [7:0] d, input string tag);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = d;
        exp_a.push_back(d);
        @(negedge clk);
        check({tag, "_t0_pipe_valid"}, 32'(a_pv_o), 1);
        check({tag, "_t0_pipe_data"}, 32'(a_pd_o), 32'(d));
        check({tag, "_t0_credit"}, 32'(u_a.credit_reg), 4);
        step();
        a_in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_t1_credit"}, 32'(u_a.credit_reg), 3);
        check({tag, "_t1_out_valid"}, 32'(a_out_valid), 0);
        check({tag, "_t1_pipe_out"}, 32'(a_pv_i), 1);
        step();
        @(negedge clk);
        check({tag, "_t2_out_valid"}, 32'(a_out_valid), 1);
        check({tag, "_t2_out_data"}, 32'(a_out_data), 32'(d));
        check({tag, "_t2_credit"}, 32'(u_a.credit_reg), 3);
        step();
        @(negedge clk);
        check({tag, "_t3_credit"}, 32'(u_a.credit_reg), 4);
        check({tag, "_t3_out_valid"}, 32'(a_out_valid), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        inject_v = 1'b1;
        inject_d = 8'hEE;

        // Reset / idle: two reset edges with pipeline-output pulses injected.
        step();
        step();
        rst      = 1'b0;
        inject_v = 1'b0;
        @(negedge clk);
        check("rst_a_in_ready", 32'(a_in_ready), 1);
        check("rst_a_out_valid", 32'(a_out_valid), 0);
        check("rst_a_credit", 32'(u_a.credit_reg), 4);
        check("rst_a_pipe_valid", 32'(a_pv_o), 0);
        check("rst_b_out_valid", 32'(b_out_valid), 0);
        check("rst_c_credit", 32'(u_c.credit_reg), 2);
        repeat (3) step();
        @(negedge clk);
        check("rst_inject_ignored", 32'(a_out_valid), 0);
        check("rst_inject_count", 32'(u_a.u_fifo.count_reg), 0);
        step();

        // Single transfer.
        single_a(8'hA5, "single");

        // Streaming at full rate.
        b_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            offer(1, 8'(i * 7 + 3), 1'b1, "b_stream_ready");
        end
        repeat (6) step();

        // Backpressure: only four credits.
        a_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(0, 8'(8'h40 + i), (i < 4), "a_bp_ready");
        end
        @(negedge clk);
        check("a_bp_count", 32'(u_a.u_fifo.count_reg), 4);
        check("a_bp_credit", 32'(u_a.credit_reg), 0);
        check("a_bp_head_valid", 32'(a_out_valid), 1);
        check("a_bp_head_data", 32'(a_out_data), 32'h40);
        step();
        a_out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("a_bp_credit_back", 32'(u_a.credit_reg), 4);
        check("a_bp_drained", 32'(a_out_valid), 0);
        check("a_bp_ready_back", 32'(a_in_ready), 1);
        step();

        // Under-provisioned depth: two accepts in every five cycles.
        c_out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            offer(2, 8'(8'h80 + i), ((i % 5) < 2), "c_ratio_ready");
        end
        repeat (6) step();

        // Reset with one word stored and one in the pipeline.
        a_out_ready = 1'b0;
        offer(0, 8'h31, 1'b1, "a_mid_ready");
        offer(0, 8'h32, 1'b1, "a_mid_ready");
        rst        = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 8'h33;
        @(negedge clk);
        check("mid_stored_visible", 32'(a_out_valid), 1);
        check("mid_rst_pipe_valid", 32'(a_pv_o), 0);
        step();
        rst        = 1'b0;
        a_in_valid = 1'b0;
        exp_a.delete();
        @(negedge clk);
        check("mid_credit", 32'(u_a.credit_reg), 4);
        check("mid_out_valid", 32'(a_out_valid), 0);
        check("mid_in_ready", 32'(a_in_ready), 1);
        check("mid_count", 32'(u_a.u_fifo.count_reg), 0);
        step();
        step();
        @(negedge clk);
        check("mid_inflight_dropped", 32'(a_out_valid), 0);
        step();
        single_a(8'h5A, "post_rst");

        repeat (3) step();
        check("a_queue_empty", 32'(exp_a.size()), 0);
        check("b_queue_empty", 32'(exp_b.size()), 0);
        check("c_queue_empty", 32'(exp_c.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
